// File: rtl/dlfloat16_mul_arb_if.sv
// rtl/dlfloat16_mul_arb_if.sv - requester, multiplier and response signals of the dlfloat16 multiplier arbiter
interface dlfloat16_mul_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [16*NREQ-1:0]      req_a;
    logic [16*NREQ-1:0]      req_b;
    logic [NREQ-1:0]         req_ready;
    logic [15:0]             mul_a;
    logic [15:0]             mul_b;
    logic [3:0]              mul_ena;
    logic [19:0]             mul_c;
    logic [4:0]              mul_flags;
    logic                    rsp_valid;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [15:0]             rsp_data;
    logic [4:0]              rsp_flags;
    logic                    rsp_ready;
    logic                    busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_c, mul_flags, rsp_ready,
        output req_ready, mul_a, mul_b, mul_ena, rsp_valid, rsp_id, rsp_data, rsp_flags, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_c, mul_flags, rsp_ready,
        input  req_ready, mul_a, mul_b, mul_ena, rsp_valid, rsp_id, rsp_data, rsp_flags, busy
    );
endinterface

// File: rtl/dlfloat16_mul_arb.sv
// rtl/dlfloat16_mul_arb.sv - round-robin sharing of one dlfloat16 multiplier with an in-order result buffer
module dlfloat16_mul_arb #(
    parameter int NREQ       = 4,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dlfloat16_mul_arb_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]     r_rr_ptr;
    logic [MUL_LAT-1:0] r_tag_v;
    logic [IDW-1:0]     r_tag_id [MUL_LAT];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_fifo_cnt;
    logic [IDW-1:0]     r_mem_id    [FIFO_DEPTH];
    logic [15:0]        r_mem_data  [FIFO_DEPTH];
    logic [4:0]         r_mem_flags [FIFO_DEPTH];

    logic               w_credit_ok;
    logic               w_found;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_rsp_valid;
    logic [IDW-1:0]     w_gidx;
    logic               w_unused;

    // Buffered plus in-flight results may never exceed the buffer, so every exit finds a free slot.
    assign w_credit_ok = (int'(r_fifo_cnt) + $countones(r_tag_v)) < FIFO_DEPTH;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req_valid[IDW'((int'(r_rr_ptr) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_gidx  = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    assign w_issue     = rst_n && w_found && w_credit_ok;
    assign w_push      = r_tag_v[MUL_LAT-1];
    assign w_rsp_valid = (r_fifo_cnt != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready;
    assign w_unused    = &{1'b0, bus.mul_c[19:16]};

    assign bus.req_ready = w_issue ? (NREQ'(1) << w_gidx) : '0;
    assign bus.mul_a     = w_issue ? bus.req_a[int'(w_gidx)*16 +: 16] : 16'h0000;
    assign bus.mul_b     = w_issue ? bus.req_b[int'(w_gidx)*16 +: 16] : 16'h0000;
    assign bus.mul_ena   = w_issue ? 4'b0010 : 4'b0000;

    // Head fields are forced to zero when empty so reset and idle present clean outputs.
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = w_rsp_valid ? r_mem_id[r_rd_ptr]    : '0;
    assign bus.rsp_data  = w_rsp_valid ? r_mem_data[r_rd_ptr]  : 16'h0000;
    assign bus.rsp_flags = w_rsp_valid ? r_mem_flags[r_rd_ptr] : 5'b00000;
    assign bus.busy      = w_rsp_valid || (|r_tag_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_tag_v    <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_gidx;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Result storage needs no reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr_ptr]    <= r_tag_id[MUL_LAT-1];
            r_mem_data[r_wr_ptr]  <= bus.mul_c[15:0];
            r_mem_flags[r_wr_ptr] <= bus.mul_flags;
        end
    end
endmodule

// File: tb/tb_dlfloat16_mul_arb.sv
// tb/tb_dlfloat16_mul_arb.sv - randomized self-checking bench for dlfloat16_mul_arb
module tb_dlfloat16_mul_arb;
    localparam int NREQ       = 4;
    localparam int MUL_LAT    = 1;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dlfloat16_mul_arb_if #(.NREQ(NREQ)) bus ();

    dlfloat16_mul_arb #(
        .NREQ(NREQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] prod_of(input logic [15:0] a, input logic [15:0] b);
        return (a * b) + 16'h0101;
    endfunction

    function automatic logic [4:0] flags_of(input logic [15:0] a, input logic [15:0] b);
        return a[4:0] ^ b[4:0];
    endfunction

    // Stand-in multiplier: registered result one cycle after an issue, junk otherwise.
    always @(posedge clk) begin
        if (bus.mul_ena == 4'b0010) begin
            bus.mul_c     <= {4'hF, prod_of(bus.mul_a, bus.mul_b)};
            bus.mul_flags <= flags_of(bus.mul_a, bus.mul_b);
        end else begin
            bus.mul_c     <= 20'($urandom);
            bus.mul_flags <= 5'($urandom);
        end
    end

    typedef struct {
        int          id;
        logic [15:0] data;
        logic [4:0]  flags;
        int          cyc;
    } rsp_t;

    rsp_t q[$];
    int   m_rr = 0;
    int   m_out = 0;
    int   cyc = 0;
    int   dut_issues = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic run_cycle();
        logic [3:0]  eg;
        int          gi;
        int          j;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] eb;
        @(negedge clk);
        eg = '0;
        gi = -1;
        ea = '0;
        eb = '0;
        if (rst_n && m_out < FIFO_DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_rr + k) % NREQ;
                if (gi < 0 && bus.req_valid[j]) gi = j;
            end
        end
        if (gi >= 0) begin
            eg[gi] = 1'b1;
            ea = bus.req_a[16*gi +: 16];
            eb = bus.req_b[16*gi +: 16];
        end
        ev = rst_n && (q.size() > 0) && (q[0].cyc + 1 + MUL_LAT <= cyc);
        if (|bus.req_ready) dut_issues++;
        chk("req_ready", 32'(bus.req_ready), 32'(eg));
        chk("mul_ena", 32'(bus.mul_ena), (gi >= 0) ? 32'h2 : 32'h0);
        chk("mul_a", 32'(bus.mul_a), 32'(ea));
        chk("mul_b", 32'(bus.mul_b), 32'(eb));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
            chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(q[0].flags));
        end else if (!rst_n) begin
            chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
            chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
            chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'h0);
        end
        chk("busy", 32'(bus.busy), 32'(rst_n && m_out != 0));
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_out = 0;
            m_rr  = 0;
        end else begin
            if (ev && bus.rsp_ready) begin
                void'(q.pop_front());
                m_out--;
            end
            if (gi >= 0) begin
                q.push_back('{id: gi, data: prod_of(ea, eb), flags: flags_of(ea, eb), cyc: cyc});
                m_out++;
                m_rr = (gi + 1) % NREQ;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[16*i +: 16] = 16'($urandom);
            bus.req_b[16*i +: 16] = 16'($urandom);
        end
    endtask

    int base;

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset holds every output low even with requests pending
        bus.req_valid = 4'hF;
        rand_operands();
        repeat (3) run_cycle();
        bus.req_valid = '0;
        rst_n = 1'b1;
        run_cycle();

        // Round robin from pointer 0 with all requesters valid
        rand_operands();
        bus.req_valid = 4'hF;
        repeat (5) run_cycle();
        bus.req_valid = '0;
        repeat (4) run_cycle();

        // Single request from requester 2
        bus.req_valid = 4'b0100;
        bus.req_a[47:32] = 16'h3E00;
        bus.req_b[47:32] = 16'h3E00;
        run_cycle();
        bus.req_valid = '0;
        repeat (4) run_cycle();
        bus.req_valid = 4'hF;
        #1;
        chk("rr_after_single", 32'(bus.req_ready), 32'h8);
        bus.req_valid = '0;
        run_cycle();

        // Back-pressure: exactly FIFO_DEPTH issues, then one more per pop
        rand_operands();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        base = dut_issues;
        repeat (8) run_cycle();
        chk("fill_issues", 32'(dut_issues - base), 32'd4);
        base = dut_issues;
        bus.rsp_ready = 1'b1;
        run_cycle();
        bus.rsp_ready = 1'b0;
        repeat (4) run_cycle();
        chk("refill_issues", 32'(dut_issues - base), 32'd1);
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        repeat (6) run_cycle();

        // Pop while the last in-flight result lands in a nearly full buffer
        rand_operands();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (4) run_cycle();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        run_cycle();
        bus.rsp_ready = 1'b0;
        repeat (3) run_cycle();
        chk("full_busy", 32'(bus.busy), 32'h1);
        bus.rsp_ready = 1'b1;
        repeat (6) run_cycle();

        // Flags pass through with the owning ID
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_a[15:0] = 16'h0004;
        bus.req_b[15:0] = 16'h0000;
        run_cycle();
        bus.req_valid = '0;
        repeat (2) run_cycle();
        chk("flag_pass", 32'(bus.rsp_flags), 32'h04);
        chk("flag_id", 32'(bus.rsp_id), 32'h0);
        bus.rsp_ready = 1'b1;
        repeat (3) run_cycle();

        // Reset with two buffered results and one in flight
        rand_operands();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (3) run_cycle();
        rst_n = 1'b0;
        repeat (2) run_cycle();
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) run_cycle();
        bus.req_valid = 4'hF;
        #1;
        chk("grant_after_reset", 32'(bus.req_ready), 32'h1);
        run_cycle();
        bus.req_valid = '0;
        repeat (4) run_cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.req_valid = 4'($urandom);
            rand_operands();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (8) run_cycle();
        chk("drained_busy", 32'(bus.busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
